// File: rtl/mem_stage.sv
// Purpose: MIPS memory stage. EX/MEM register, data-cache request FSM, MEM/WB register, branch resolve.
// Latency: 1 cycle EX->EX/MEM, 1 more cycle to MEM/WB; loads add one cycle per cache wait cycle.
// Backpressure: dmem_ready low on a request holds EX/MEM and raises mem_stall_out to freeze upstream.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   *_in                             execute-stage results and control bits, flush_in bubbles EX/MEM
//   dmem_req/we/addr/wdata           data-cache request, held stable until dmem_ready
//   dmem_rdata/dmem_ready            data-cache response
//   mem_stall_out                    freeze PC, IF/ID and ID/EX
//   pc_src_out, branch_target_out    taken-branch redirect
//   ex_mem_*_out, mem_wb_*_out       forwarding sources and write-back entry
//   stall_cycles_out                 saturating count of stalled cycles

module mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   // execute stage
   input  logic [31:0] alu_result_in,
   input  logic [31:0] reg_data2_fwd_in,
   input  logic [31:0] branch_target_in,
   input  logic        zero_flag_in,
   input  logic [4:0]  rd_addr_final_in,
   input  logic        mem_to_reg_in,
   input  logic        reg_write_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic        branch_in,
   input  logic        flush_in,
   // data cache
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   // hazard / branch
   output logic        mem_stall_out,
   output logic        pc_src_out,
   output logic [31:0] branch_target_out,
   // forwarding and write-back
   output logic [31:0] ex_mem_result_out,
   output logic [4:0]  ex_mem_rd_addr_out,
   output logic        ex_mem_reg_write_out,
   output logic [31:0] mem_wb_result_out,
   output logic [4:0]  mem_wb_rd_addr_out,
   output logic        mem_wb_reg_write_out,
   // statistics
   output logic [31:0] stall_cycles_out
);

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [31:0] target;
      logic        zero;
      logic [4:0]  rd;
      logic        mem_to_reg;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
   } ex_mem_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   ex_mem_t     ex_mem_q, ex_mem_d;
   state_t      state_q, state_d;
   logic [31:0] mem_wb_result_q, mem_wb_result_d;
   logic [4:0]  mem_wb_rd_addr_q, mem_wb_rd_addr_d;
   logic        mem_wb_reg_write_q, mem_wb_reg_write_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   logic        memop;
   logic        stall;

   // ------------------------------------------------------------------
   // Cache request. The request is a pure function of the EX/MEM entry
   // (plus the WAIT state), so an asynchronous reset that clears EX/MEM
   // drops dmem_req immediately. Since EX/MEM is held while waiting, the
   // address, direction and data are stable for the whole transaction.
   // ------------------------------------------------------------------
   assign memop      = ex_mem_q.mem_read | ex_mem_q.mem_write;
   assign dmem_req   = memop | (state_q == ST_WAIT);
   // mem_write wins when both read and write are set: treated as a store.
   assign dmem_we    = ex_mem_q.mem_write;
   assign dmem_addr  = {ex_mem_q.alu[31:2], 2'b00};
   assign dmem_wdata = ex_mem_q.wdata;

   // dmem_ready is only meaningful while a request is out.
   assign stall         = dmem_req & ~dmem_ready;
   assign mem_stall_out = stall;

   // ------------------------------------------------------------------
   // FSM: tracks whether a request is outstanding across cycles.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (dmem_req && !dmem_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dmem_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // EX/MEM: stall holds, otherwise flush inserts a bubble, otherwise load.
   // Stall must win so a waiting memory op is not lost to a flush.
   // ------------------------------------------------------------------
   always_comb begin
      ex_mem_d = ex_mem_q;
      if (!stall) begin
         if (flush_in) begin
            ex_mem_d = '0;
         end else begin
            ex_mem_d.alu        = alu_result_in;
            ex_mem_d.wdata      = reg_data2_fwd_in;
            ex_mem_d.target     = branch_target_in;
            ex_mem_d.zero       = zero_flag_in;
            ex_mem_d.rd         = rd_addr_final_in;
            ex_mem_d.mem_to_reg = mem_to_reg_in;
            ex_mem_d.reg_write  = reg_write_in;
            ex_mem_d.mem_read   = mem_read_in;
            ex_mem_d.mem_write  = mem_write_in;
            ex_mem_d.branch     = branch_in;
         end
      end
   end

   // ------------------------------------------------------------------
   // MEM/WB: a stalled cycle sends a bubble downstream by clearing only
   // reg_write; result and rd_addr keep their old values.
   // ------------------------------------------------------------------
   always_comb begin
      mem_wb_result_d    = mem_wb_result_q;
      mem_wb_rd_addr_d   = mem_wb_rd_addr_q;
      mem_wb_reg_write_d = mem_wb_reg_write_q;
      if (stall) begin
         mem_wb_reg_write_d = 1'b0;
      end else begin
         mem_wb_result_d    = ex_mem_q.mem_to_reg ? dmem_rdata : ex_mem_q.alu;
         mem_wb_rd_addr_d   = ex_mem_q.rd;
         mem_wb_reg_write_d = ex_mem_q.reg_write;
      end
   end

   // Saturating stall counter.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q            <= ST_IDLE;
         ex_mem_q           <= '0;
         mem_wb_result_q    <= '0;
         mem_wb_rd_addr_q   <= '0;
         mem_wb_reg_write_q <= 1'b0;
         stall_cnt_q        <= '0;
      end else begin
         state_q            <= state_d;
         ex_mem_q           <= ex_mem_d;
         mem_wb_result_q    <= mem_wb_result_d;
         mem_wb_rd_addr_q   <= mem_wb_rd_addr_d;
         mem_wb_reg_write_q <= mem_wb_reg_write_d;
         stall_cnt_q        <= stall_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // A branch entry is never a memop, so this is high for exactly the one
   // cycle the branch sits in EX/MEM; the hazard unit flushes behind it.
   assign pc_src_out           = ex_mem_q.branch & ex_mem_q.zero;
   assign branch_target_out    = ex_mem_q.target;

   assign ex_mem_result_out    = ex_mem_q.alu;
   assign ex_mem_rd_addr_out   = ex_mem_q.rd;
   assign ex_mem_reg_write_out = ex_mem_q.reg_write;

   assign mem_wb_result_out    = mem_wb_result_q;
   assign mem_wb_rd_addr_out   = mem_wb_rd_addr_q;
   assign mem_wb_reg_write_out = mem_wb_reg_write_q;

   assign stall_cycles_out     = stall_cnt_q;

endmodule
